hex_uart_tx: RTL and testbench

Debug console stage directly downstream of the SoC top. It consumes the SoC hex output byte and error flag, queues every change, and serialises it on a UART 8N1 line. Each byte is sent as two uppercase ASCII hex characters; each error event is sent as '!'. When enabled, each record is followed by CR LF. Bench/FPGA observation of program output happens without a display.

---
 rtl/soc_debug_pkg.sv | 34 +++
 rtl/sync_fifo.sv | 55 +++++
 rtl/hex_uart_tx.sv | 253 +++++++++++++++++++++++++
 tb/tb_hex_uart_tx.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_debug_pkg.sv
// Shared types and helpers for the SoC debug console UART path:
// FSM encodings, record format and ASCII conversion.
package soc_debug_pkg;

  typedef enum logic [1:0] {
    BIT_IDLE,
    BIT_START,
    BIT_DATA,
    BIT_STOP
  } bit_state_e;

  typedef enum logic [1:0] {
    SEL_HI,
    SEL_LO,
    SEL_CR,
    SEL_LF
  } char_sel_e;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_BANG = 8'h21;

  // One queued console event: a hex byte, or an error marker when err is set.
  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } hex_rec_t;

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else return 8'h37 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; a push on a full queue is accepted
// when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];
  assign count   = cnt_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/hex_uart_tx.sv
// Debug console: queues every change of the SoC hex byte / error flag and
// prints it on a UART 8N1 line as two hex digits or '!', optionally plus CR LF.
module hex_uart_tx
  import soc_debug_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4,
  parameter int SEND_NEWLINE = 1
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic [7:0] i_hex_byte,
  input  logic       i_error,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_overflow
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int OCC_W  = CNT_W + 1;
  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [OCC_W-1:0]  DEPTH_OCC   = OCC_W'(FIFO_DEPTH);
  localparam bit NEWLINE = (SEND_NEWLINE != 0);

  logic [7:0] prev_byte;
  logic       prev_error;
  logic       byte_chg;
  logic       err_rise;

  hex_rec_t   stage_q [2];
  hex_rec_t   stage_n [2];
  logic [1:0] stage_cnt;
  logic [1:0] stage_cnt_n;
  hex_rec_t   cand [3];
  logic [1:0] n_cand;
  logic [OCC_W-1:0] room;
  logic       drop;
  logic       overflow_q;

  logic       fifo_push;
  hex_rec_t   fifo_wdata;
  logic       fifo_pop;
  logic [8:0] fifo_rdata;
  logic       fifo_full;
  logic       fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  bit_state_e        state, state_n;
  logic [BAUD_W-1:0] baud_cnt, baud_n;
  logic [2:0]        bit_idx, bit_idx_n;
  char_sel_e         char_sel, sel_n, sel_next;
  hex_rec_t          cur_rec, rec_n;
  logic              has_next;
  logic              bit_done;
  logic [7:0]        char_n;
  logic              tx_q, tx_n;
  logic              busy_q, busy_n;

  function automatic logic [7:0] char_of(input hex_rec_t r, input char_sel_e s);
    case (s)
      SEL_HI:  return r.err ? ASCII_BANG : nibble_to_ascii(r.data[7:4]);
      SEL_LO:  return nibble_to_ascii(r.data[3:0]);
      SEL_CR:  return ASCII_CR;
      default: return ASCII_LF;
    endcase
  endfunction

  assign byte_chg = (i_hex_byte != prev_byte);
  assign err_rise = i_error && !prev_error;

  // Staged records are always older than this cycle's events, so they go
  // first. The staging slots count against queue capacity, which keeps the
  // FIFO itself from ever refusing a push.
  always_comb begin
    cand[0]  = stage_q[0];
    cand[1]  = stage_q[1];
    cand[2]  = '0;
    n_cand   = stage_cnt;
    room     = DEPTH_OCC - (OCC_W'(fifo_count) + OCC_W'(stage_cnt)) + OCC_W'(fifo_pop);
    drop     = 1'b0;
    if (byte_chg) begin
      if (room != '0 && n_cand != 2'd3) begin
        cand[n_cand] = '{err: 1'b0, data: i_hex_byte};
        n_cand       = n_cand + 2'd1;
        room         = room - 1'b1;
      end else begin
        drop = 1'b1;
      end
    end
    if (err_rise) begin
      if (room != '0 && n_cand != 2'd3) begin
        cand[n_cand] = '{err: 1'b1, data: 8'h00};
        n_cand       = n_cand + 2'd1;
      end else begin
        drop = 1'b1;
      end
    end
    fifo_push   = (n_cand != 2'd0) && (!fifo_full || fifo_pop);
    fifo_wdata  = cand[0];
    stage_cnt_n = (n_cand == 2'd0) ? 2'd0 : n_cand - 2'd1;
    stage_n[0]  = cand[1];
    stage_n[1]  = cand[2];
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      prev_byte  <= 8'h00;
      prev_error <= 1'b0;
      stage_q[0] <= '0;
      stage_q[1] <= '0;
      stage_cnt  <= 2'd0;
      overflow_q <= 1'b0;
    end else begin
      prev_byte  <= i_hex_byte;
      prev_error <= i_error;
      stage_q[0] <= stage_n[0];
      stage_q[1] <= stage_n[1];
      stage_cnt  <= stage_cnt_n;
      overflow_q <= overflow_q | drop;
    end
  end

  sync_fifo #(
    .WIDTH($bits(hex_rec_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_clock),
    .rst_n (i_reset),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    has_next = 1'b0;
    sel_next = SEL_LF;
    case (char_sel)
      SEL_HI: begin
        if (!cur_rec.err) begin
          has_next = 1'b1;
          sel_next = SEL_LO;
        end else if (NEWLINE) begin
          has_next = 1'b1;
          sel_next = SEL_CR;
        end
      end
      SEL_LO: begin
        if (NEWLINE) begin
          has_next = 1'b1;
          sel_next = SEL_CR;
        end
      end
      SEL_CR: begin
        has_next = 1'b1;
        sel_next = SEL_LF;
      end
      default: ;
    endcase
  end

  assign bit_done = (baud_cnt == '0);

  // Every bit loads the reload value on entry and ends when the count hits 0.
  always_comb begin
    state_n   = state;
    baud_n    = baud_cnt;
    bit_idx_n = bit_idx;
    sel_n     = char_sel;
    rec_n     = cur_rec;
    fifo_pop  = 1'b0;
    case (state)
      BIT_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          rec_n    = fifo_rdata;
          sel_n    = SEL_HI;
          state_n  = BIT_START;
          baud_n   = BAUD_RELOAD;
        end
      end
      BIT_START: begin
        if (bit_done) begin
          state_n   = BIT_DATA;
          bit_idx_n = 3'd0;
          baud_n    = BAUD_RELOAD;
        end else begin
          baud_n = baud_cnt - 1'b1;
        end
      end
      BIT_DATA: begin
        if (bit_done) begin
          baud_n = BAUD_RELOAD;
          if (bit_idx == 3'd7) state_n = BIT_STOP;
          else bit_idx_n = bit_idx + 3'd1;
        end else begin
          baud_n = baud_cnt - 1'b1;
        end
      end
      default: begin
        if (bit_done) begin
          if (has_next) begin
            sel_n   = sel_next;
            state_n = BIT_START;
            baud_n  = BAUD_RELOAD;
          end else begin
            state_n = BIT_IDLE;
          end
        end else begin
          baud_n = baud_cnt - 1'b1;
        end
      end
    endcase

    // Line and busy are driven from next-state values so both are registered.
    char_n = char_of(rec_n, sel_n);
    case (state_n)
      BIT_START: tx_n = 1'b0;
      BIT_DATA:  tx_n = char_n[bit_idx_n];
      default:   tx_n = 1'b1;
    endcase
    busy_n = (state_n != BIT_IDLE) || !fifo_empty || (stage_cnt != 2'd0);
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state    <= BIT_IDLE;
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      char_sel <= SEL_HI;
      cur_rec  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_idx  <= bit_idx_n;
      char_sel <= sel_n;
      cur_rec  <= rec_n;
      tx_q     <= tx_n;
      busy_q   <= busy_n;
    end
  end

  assign o_tx       = tx_q;
  assign o_busy     = busy_q;
  assign o_overflow = overflow_q;

endmodule

// File: tb/tb_hex_uart_tx.sv
// Scoreboard bench for hex_uart_tx: two instances (with and without CR LF)
// and a UART receiver per instance that decodes frames against queued chars.
module tb_hex_uart_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] byte_a, byte_b;
  logic       err_a, err_b;
  logic       tx_a, busy_a, ovf_a;
  logic       tx_b, busy_b, ovf_b;

  int  n_cmp = 0;
  int  n_err = 0;
  bit  mon_en = 1'b1;
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];

  always #5 clk = ~clk;

  hex_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .SEND_NEWLINE(1)) u_dut_a (
    .i_clock    (clk),
    .i_reset    (rst_n),
    .i_hex_byte (byte_a),
    .i_error    (err_a),
    .o_tx       (tx_a),
    .o_busy     (busy_a),
    .o_overflow (ovf_a)
  );

  hex_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .SEND_NEWLINE(0)) u_dut_b (
    .i_clock    (clk),
    .i_reset    (rst_n),
    .i_hex_byte (byte_b),
    .i_error    (err_b),
    .o_tx       (tx_b),
    .o_busy     (busy_b),
    .o_overflow (ovf_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    string digits;
    digits = "0123456789ABCDEF";
    return digits.getc(int'(nib));
  endfunction

  // Instance 0 appends CR LF, instance 1 does not.
  task automatic expect_rec(input int which, input logic [7:0] d, input bit is_err);
    logic [7:0] chars[$];
    if (is_err) chars.push_back(8'h21);
    else begin
      chars.push_back(hex_char(d[7:4]));
      chars.push_back(hex_char(d[3:0]));
    end
    if (which == 0) begin
      chars.push_back(8'h0D);
      chars.push_back(8'h0A);
    end
    foreach (chars[i]) begin
      if (which == 0) exp_a.push_back(chars[i]);
      else exp_b.push_back(chars[i]);
    end
  endtask

  function automatic logic tx_of(input int which);
    return (which == 0) ? tx_a : tx_b;
  endfunction

  task automatic uart_mon(input int which);
    logic [7:0] ch;
    logic       line;
    bit         have;
    logic [7:0] want;
    string      sfx;
    sfx = (which == 0) ? "a" : "b";
    forever begin
      @(negedge clk);
      if (rst_n && tx_of(which) == 1'b0) begin
        repeat (2) @(negedge clk);
        line = tx_of(which);
        if (mon_en) check_eq({"start_bit_", sfx}, line, 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          ch[i] = tx_of(which);
        end
        repeat (CPB) @(negedge clk);
        line = tx_of(which);
        if (mon_en) begin
          check_eq({"stop_bit_", sfx}, line, 1'b1);
          have = 1'b0;
          want = 8'h00;
          if (which == 0) begin
            have = (exp_a.size() != 0);
            if (have) want = exp_a.pop_front();
          end else begin
            have = (exp_b.size() != 0);
            if (have) want = exp_b.pop_front();
          end
          check_eq({"char_queued_", sfx}, have, 1'b1);
          if (have) check_eq({"char_", sfx}, ch, want);
        end
        repeat (CPB - 3) @(negedge clk);
      end
    end
  endtask

  task automatic wait_drain(input int which, input int budget, input string tag);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(posedge clk);
      #1;
      if (which == 0) done = (exp_a.size() == 0) && !busy_a;
      else done = (exp_b.size() == 0) && !busy_b;
    end
    check_eq(tag, done, 1'b1);
  endtask

  initial begin
    fork
      uart_mon(0);
      uart_mon(1);
    join_none
  end

  initial begin
    int bad;
    int busy_cnt;
    logic [7:0] burst [6];
    burst[0] = 8'h09; burst[1] = 8'h9A; burst[2] = 8'hB0;
    burst[3] = 8'hC1; burst[4] = 8'hDE; burst[5] = 8'h77;

    rst_n  = 1'b0;
    byte_a = 8'h00;
    byte_b = 8'h00;
    err_a  = 1'b0;
    err_b  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_tx_a", tx_a, 1'b1);
    check_eq("rst_busy_a", busy_a, 1'b0);
    check_eq("rst_ovf_a", ovf_a, 1'b0);
    check_eq("rst_tx_b", tx_b, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // Quiet line after reset
    bad = 0;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (tx_a !== 1'b1 || busy_a !== 1'b0 || tx_b !== 1'b1 || busy_b !== 1'b0) bad++;
    end
    check_eq("idle_100_cycles", bad, 0);

    // Byte 0x3A: latency and busy length
    @(negedge clk);
    byte_a = 8'h3A;
    expect_rec(0, 8'h3A, 1'b0);
    @(posedge clk);
    #1;
    check_eq("lat_edge_k_tx", tx_a, 1'b1);
    check_eq("lat_edge_k_busy", busy_a, 1'b0);
    @(posedge clk);
    #1;
    check_eq("lat_edge_k1_tx", tx_a, 1'b0);
    busy_cnt = 0;
    for (int c = 0; c < 400 && busy_a; c++) begin
      busy_cnt++;
      @(posedge clk);
      #1;
    end
    check_eq("busy_len_3a", busy_cnt, 160);
    wait_drain(0, 100, "drain_3a");

    // Error rise, held high, then re-armed
    @(negedge clk);
    err_a = 1'b1;
    expect_rec(0, 8'h00, 1'b1);
    wait_drain(0, 300, "drain_err1");
    busy_cnt = 0;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (busy_a) busy_cnt++;
    end
    check_eq("err_held_no_repeat", busy_cnt, 0);
    @(negedge clk);
    err_a = 1'b0;
    @(negedge clk);
    err_a = 1'b1;
    expect_rec(0, 8'h00, 1'b1);
    wait_drain(0, 300, "drain_err2");
    @(negedge clk);
    err_a = 1'b0;

    // Simultaneous byte change and error rise
    @(negedge clk);
    byte_a = 8'h5F;
    err_a  = 1'b1;
    expect_rec(0, 8'h5F, 1'b0);
    expect_rec(0, 8'h00, 1'b1);
    wait_drain(0, 600, "drain_dual");
    @(negedge clk);
    err_a = 1'b0;
    check_eq("ovf_before_burst", ovf_a, 1'b0);

    // Six changes back to back: last one overflows
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      byte_a = burst[i];
      if (i < 5) expect_rec(0, burst[i], 1'b0);
    end
    @(posedge clk);
    #1;
    check_eq("ovf_after_burst", ovf_a, 1'b1);
    wait_drain(0, 1500, "drain_burst");
    check_eq("ovf_sticky", ovf_a, 1'b1);

    // No-newline instance: 0xFF gives two frames
    @(negedge clk);
    byte_b = 8'hFF;
    expect_rec(1, 8'hFF, 1'b0);
    @(posedge clk);
    #1;
    check_eq("nl0_edge_k_tx", tx_b, 1'b1);
    @(posedge clk);
    #1;
    check_eq("nl0_edge_k1_tx", tx_b, 1'b0);
    busy_cnt = 0;
    for (int c = 0; c < 300 && busy_b; c++) begin
      busy_cnt++;
      @(posedge clk);
      #1;
    end
    check_eq("busy_len_nl0", busy_cnt, 80);
    wait_drain(1, 100, "drain_nl0");

    // Reset in the middle of a frame
    mon_en = 1'b0;
    @(negedge clk);
    byte_a = 8'h12;
    repeat (15) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("abort_tx", tx_a, 1'b1);
    check_eq("abort_busy", busy_a, 1'b0);
    check_eq("abort_ovf_cleared", ovf_a, 1'b0);
    byte_a = 8'h00;
    byte_b = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (tx_a !== 1'b1 || busy_a !== 1'b0) bad++;
    end
    check_eq("idle_after_abort", bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
